ex_mem_stage: RTL
=================

// Module: ex_mem_stage
// PURPOSE
// - EX->MEM pipeline register of the 5-stage RV32I core. Sits directly after the ALU and captures
//   ALUOut, Zero and Negative together with the EX-stage control bits.
// - Resolves branches/jumps from the ALU flags. Issues a registered PC redirect and a front-end
//   flush, squashes the one wrong-path shadow instruction, and counts branch events.
// PARAMETERS
// - XLEN   32  datapath width
// - CNT_W  32  width of the branch event counters
// PORTS
// - clk             in   1     core clock
// - rst             in   1     synchronous, active-high reset
// - ex_valid        in   1     EX holds a real instruction
// - ex_alu_out      in   XLEN  ALU result
// - ex_zero         in   1     ALU Zero flag
// - ex_negative     in   1     ALU Negative flag
// - ex_rs2_data     in   XLEN  forwarded rs2 (store data)
// - ex_rd           in   5     destination register
// - ex_reg_write    in   1     writeback enable
// - ex_mem_read     in   1     load
// - ex_mem_write    in   1     store
// - ex_funct3       in   3     funct3 (branch type / load-store size)
// - ex_branch       in   1     conditional branch
// - ex_jump         in   1     JAL/JALR
// - ex_target       in   XLEN  branch/jump target
// - ex_pc_plus4     in   XLEN  link value
// - mem_stall       in   1     MEM cannot accept this cycle
// - ex_ready        out  1     = !mem_stall
// - mem_valid, mem_alu_out, mem_store_data, mem_rd, mem_reg_write, mem_mem_read, mem_mem_write,
//   mem_funct3, mem_negative   out  (widths as EX)   registered EX/MEM fields
// - redirect_valid  out  1     one-cycle PC redirect
// - redirect_pc     out  XLEN  redirect target
// - flush_front     out  1     flush IF/ID and ID/EX; has priority over front-end stall
// - misalign_trap   out  1     one-cycle pulse: taken target not 4-byte aligned
// - cnt_branches    out  CNT_W conditional branches retired into MEM
// - cnt_taken       out  CNT_W taken conditional branches
// BEHAVIOUR
// - Reset: every output and counter is 0; FSM goes to NORMAL. rst overrides all, including a pending redirect.
// - accept = ex_valid & !mem_stall & (state==NORMAL). Latency EX->MEM is 1 cycle.
// - mem_stall=1: every mem_* field holds its value. No new resolution, no counting.
// - !mem_stall & !accept: insert a bubble. mem_valid, mem_reg_write, mem_mem_read and mem_mem_write go to 0;
//   data fields hold.
// - On accept, mem_alu_out = ex_jump ? ex_pc_plus4 : ex_alu_out. All other fields copy from EX.
// - Branch condition (decoder issues SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU):
//   - taken on Zero: BEQ 000, BGE 101, BGEU 111
//   - taken on !Zero: BNE 001, BLT 100, BLTU 110
//   - any other funct3: not taken
// - take = ex_jump | (ex_branch & cond). For a jump, tgt = ex_target with bit0 cleared.
// - take & tgt[1]==1: next cycle misalign_trap=1 and no redirect. Instruction enters MEM with mem_valid=0.
// - take & aligned on accept: next cycle redirect_valid=1, redirect_pc=tgt, flush_front=1, each exactly 1 cycle.
//   FSM goes NORMAL->SHADOW.
// - SHADOW lasts exactly one cycle, then returns to NORMAL. The EX content that cycle is wrong-path: not
//   captured, not resolved, not counted. A mem_stall in SHADOW still holds MEM, and SHADOW still ends.
// - Counters increment on accept only: cnt_branches on ex_branch, cnt_taken on ex_branch&cond.
//   Jumps are not counted. Counters wrap from 2^CNT_W-1 to 0.
// STRUCTURE
// - core_pkg holds:
//   - F3_BEQ..F3_BGEU localparams
//   - ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_SLT=4'b1000, ALU_SLTU=4'b1001
//   - typedef struct packed ex_mem_t for the MEM fields
//   - typedef enum {NORMAL, SHADOW} resolve_state_t
// - One combinational sub-module: branch_cond (funct3, zero -> cond). Everything else stays inline.
// TESTING
// - BEQ, ex_zero=1, target 0x100 -> next cycle redirect_valid=1, redirect_pc=0x100, flush_front=1,
//   cnt_branches=1, cnt_taken=1.
// - BNE, ex_zero=1 -> no redirect; mem_valid=1; cnt_branches=1, cnt_taken=0.
// - JAL, target 0x202, pc+4=0x44 -> misalign_trap=1, no redirect, mem_valid=0.
// - JALR, target 0x201 -> redirect_pc=0x200; mem_alu_out=0x44.
// - Taken BLT, then mem_stall=1 in SHADOW with ex_valid=1 -> shadow op never reaches MEM; MEM holds the
//   branch; the redirect still pulses once.
// - rst asserted in the cycle after a taken branch -> redirect_valid=0 next cycle, all outputs 0.
//   Separately, preload cnt_taken=2^32-1 and take a branch -> wraps to 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline: branch funct3 encodings,
// ALU operation codes, the EX/MEM pipeline record and the branch-resolve states.
package core_pkg;

    localparam int DATA_W = 32;

    // Branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // ALU operations the decoder picks for branch comparisons
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Fields carried from EX into MEM
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] store_data;
        logic [4:0]        rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [2:0]        funct3;
        logic              negative;
    } ex_mem_t;

    typedef enum logic {
        NORMAL = 1'b0,
        SHADOW = 1'b1
    } resolve_state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition from the ALU Zero flag. The decoder issues SUB for BEQ/BNE
// and SLT/SLTU for the ordered compares, so every branch reduces to Zero or !Zero.
module branch_cond
    import core_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    output logic       cond
);

    // Map funct3 to taken-on-zero / taken-on-nonzero; unknown encodings never branch
    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ, F3_BGE, F3_BGEU: cond = zero;
            F3_BNE, F3_BLT, F3_BLTU: cond = ~zero;
            default:                 cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with branch/jump resolution, PC redirect,
// one-instruction wrong-path squash and branch event counters.
//
// state  | meaning
// NORMAL | EX content is on the correct path; accept and resolve it
// SHADOW | EX holds the wrong-path instruction fetched behind a taken
//        | redirect; drop it and return to NORMAL after one cycle
//
// The MEM record is sized by core_pkg::DATA_W, so XLEN must stay equal to it.
module ex_mem_stage
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_out,
    input  logic            ex_zero,
    input  logic            ex_negative,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic [XLEN-1:0] ex_target,
    input  logic [XLEN-1:0] ex_pc_plus4,
    input  logic            mem_stall,
    output logic            ex_ready,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_alu_out,
    output logic [XLEN-1:0] mem_store_data,
    output logic [4:0]      mem_rd,
    output logic            mem_reg_write,
    output logic            mem_mem_read,
    output logic            mem_mem_write,
    output logic [2:0]      mem_funct3,
    output logic            mem_negative,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_front,
    output logic            misalign_trap,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_taken
);

    resolve_state_t state_q, state_d;
    ex_mem_t        mem_q, mem_d;

    logic            cond;
    logic            accept;
    logic            take;
    logic            misalign;
    logic            redirect_d;
    logic [XLEN-1:0] tgt;

    logic            redirect_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            trap_q;
    logic [CNT_W-1:0] cnt_branches_q;
    logic [CNT_W-1:0] cnt_taken_q;

    branch_cond u_branch_cond (
        .funct3 (ex_funct3),
        .zero   (ex_zero),
        .cond   (cond)
    );

    // Resolution: JALR targets may carry bit0 set, which the ISA discards
    always_comb begin
        accept     = ex_valid & ~mem_stall & (state_q == NORMAL);
        tgt        = ex_jump ? {ex_target[XLEN-1:1], 1'b0} : ex_target;
        take       = ex_jump | (ex_branch & cond);
        misalign   = take & tgt[1];
        redirect_d = accept & take & ~tgt[1];
    end

    // Resolve-state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= NORMAL;
        else     state_q <= state_d;
    end

    // Next-state: a redirect opens a one-cycle shadow, which always closes
    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL: if (redirect_d) state_d = SHADOW;
            SHADOW: state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    // Next MEM record: hold on stall, capture on accept, otherwise bubble
    always_comb begin
        mem_d = mem_q;
        if (!mem_stall) begin
            if (accept) begin
                mem_d.valid      = ~misalign;
                mem_d.alu_out    = ex_jump ? ex_pc_plus4 : ex_alu_out;
                mem_d.store_data = ex_rs2_data;
                mem_d.rd         = ex_rd;
                mem_d.reg_write  = ex_reg_write;
                mem_d.mem_read   = ex_mem_read;
                mem_d.mem_write  = ex_mem_write;
                mem_d.funct3     = ex_funct3;
                mem_d.negative   = ex_negative;
            end else begin
                mem_d.valid     = 1'b0;
                mem_d.reg_write = 1'b0;
                mem_d.mem_read  = 1'b0;
                mem_d.mem_write = 1'b0;
            end
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
    end

    // Redirect/trap pulses; redirect_pc keeps the last target between redirects
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            trap_q        <= 1'b0;
        end else begin
            redirect_q <= redirect_d;
            trap_q     <= accept & misalign;
            if (redirect_d) redirect_pc_q <= tgt;
        end
    end

    // Branch event counters, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_branches_q <= '0;
            cnt_taken_q    <= '0;
        end else if (accept && ex_branch) begin
            cnt_branches_q <= cnt_branches_q + 1'b1;
            if (cond) cnt_taken_q <= cnt_taken_q + 1'b1;
        end
    end

    assign ex_ready       = ~mem_stall;
    assign mem_valid      = mem_q.valid;
    assign mem_alu_out    = mem_q.alu_out;
    assign mem_store_data = mem_q.store_data;
    assign mem_rd         = mem_q.rd;
    assign mem_reg_write  = mem_q.reg_write;
    assign mem_mem_read   = mem_q.mem_read;
    assign mem_mem_write  = mem_q.mem_write;
    assign mem_funct3     = mem_q.funct3;
    assign mem_negative   = mem_q.negative;
    assign redirect_valid = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_front    = redirect_q;
    assign misalign_trap  = trap_q;
    assign cnt_branches   = cnt_branches_q;
    assign cnt_taken      = cnt_taken_q;

endmodule
